// File: rtl/dma_port_pkg.sv
// Shared accelerator definitions: DMA port state encoding, burst defaults
// and engine op-type constants.
package dma_port_pkg;

  localparam int DEFAULT_BURST_LEN = 16;
  localparam int DEFAULT_ADDR_W    = 30;
  localparam int CMD_BL_W          = 6;

  // Engine op types double as the memory command instruction bit
  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CMD   = 3'd1,
    RD_DATA  = 3'd2,
    WR_FILL  = 3'd3,
    WR_DRAIN = 3'd4,
    WR_CMD   = 3'd5
  } dma_state_e;

  // Burst counters must reach BURST_LEN itself, hence the extra bit
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/dma_port_if.sv
// Engine and memory-controller signals of the DMA port, seen from the port
// (master) and from the surrounding engine/memory (slave).
interface dma_port_if
  import dma_port_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              reads_en;
  logic              writes_en;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       ob_data;
  logic              ob_we;
  logic              ib_re;
  logic [15:0]       ib_data;
  logic              ib_valid;
  logic              mem_cmd_en;
  logic              mem_cmd_instr;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [CMD_BL_W-1:0] mem_cmd_bl;
  logic              mem_cmd_full;
  logic [15:0]       mem_rd_data;
  logic              mem_rd_valid;
  logic [15:0]       mem_wr_data;
  logic              mem_wr_en;
  logic              mem_wr_full;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  reads_en, writes_en, addr, ib_data, ib_valid,
           mem_cmd_full, mem_rd_data, mem_rd_valid, mem_wr_full,
    output ob_data, ob_we, ib_re, mem_cmd_en, mem_cmd_instr, mem_cmd_addr,
           mem_cmd_bl, mem_wr_data, mem_wr_en, busy, done, err
  );

  modport slave (
    output reads_en, writes_en, addr, ib_data, ib_valid,
           mem_cmd_full, mem_rd_data, mem_rd_valid, mem_wr_full,
    input  ob_data, ob_we, ib_re, mem_cmd_en, mem_cmd_instr, mem_cmd_addr,
           mem_cmd_bl, mem_wr_data, mem_wr_en, busy, done, err
  );

endinterface

// File: rtl/dma_wbuf.sv
// Write-burst staging buffer: DEPTH x 16 register file, one synchronous
// write port and one combinational read port, cleared by reset.
module dma_wbuf
  import dma_port_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BURST_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [15:0]                wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [15:0]                rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-power-of-two depths leave unused addresses; read those as zero
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/dma_port.sv
// DMA port: turns engine read/write burst requests into memory-controller
// commands, streaming read words out and staging write words in dma_wbuf.
module dma_port
  import dma_port_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input logic        clk,
  input logic        rst,
  dma_port_if.master bus
);

  localparam int CW = cnt_width(BURST_LEN);
  localparam int AW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BURST_LEN);

  dma_state_e state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     req_cnt, rx_cnt, tx_cnt, rd_cnt;
  logic [15:0]       ob_data_q;
  logic              ob_we_q, done_q, err_q;
  logic [15:0]       wbuf_rdata;

  logic start, rd_take, ib_take, wr_push, cmd_en, cmd_instr, ib_re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    rd_take   = 1'b0;
    ib_take   = 1'b0;
    wr_push   = 1'b0;
    cmd_en    = 1'b0;
    cmd_instr = OP_WRITE;
    ib_re     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.reads_en) begin
          state_nxt = RD_CMD;
          start     = 1'b1;
        end else if (bus.writes_en) begin
          state_nxt = WR_FILL;
          start     = 1'b1;
        end
      end
      RD_CMD: begin
        cmd_instr = OP_READ;
        if (!bus.mem_cmd_full) begin
          cmd_en    = 1'b1;
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        rd_take = bus.mem_rd_valid;
        if (bus.mem_rd_valid && rd_cnt == LAST_CNT) begin
          state_nxt = IDLE;
        end
      end
      // Words beyond a full buffer are silently dropped
      WR_FILL: begin
        ib_re   = (req_cnt < FULL_CNT);
        ib_take = bus.ib_valid && (rx_cnt < FULL_CNT);
        if (rx_cnt == FULL_CNT) begin
          state_nxt = WR_DRAIN;
        end
      end
      WR_DRAIN: begin
        if (!bus.mem_wr_full) begin
          wr_push = 1'b1;
          if (tx_cnt == LAST_CNT) begin
            state_nxt = WR_CMD;
          end
        end
      end
      WR_CMD: begin
        if (!bus.mem_cmd_full) begin
          cmd_en    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      req_cnt   <= '0;
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      rd_cnt    <= '0;
      ob_data_q <= '0;
      ob_we_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ob_we_q <= rd_take;
      done_q  <= (rd_take && rd_cnt == LAST_CNT) || (state == WR_CMD && cmd_en);
      if (rd_take) begin
        ob_data_q <= bus.mem_rd_data;
        rd_cnt    <= rd_cnt + CW'(1);
      end
      if (start) begin
        addr_q  <= bus.addr;
        req_cnt <= '0;
        rx_cnt  <= '0;
        tx_cnt  <= '0;
        rd_cnt  <= '0;
      end
      if (ib_re) begin
        req_cnt <= req_cnt + CW'(1);
      end
      if (ib_take) begin
        rx_cnt <= rx_cnt + CW'(1);
      end
      if (wr_push) begin
        tx_cnt <= tx_cnt + CW'(1);
      end
      // Stray data outside its phase is discarded but flagged until reset
      if ((bus.mem_rd_valid && state != RD_DATA) ||
          (bus.ib_valid && state != WR_FILL)) begin
        err_q <= 1'b1;
      end
    end
  end

  dma_wbuf #(
    .DEPTH (BURST_LEN)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .we    (ib_take),
    .waddr (rx_cnt[AW-1:0]),
    .wdata (bus.ib_data),
    .raddr (tx_cnt[AW-1:0]),
    .rdata (wbuf_rdata)
  );

  assign bus.ob_data       = ob_data_q;
  assign bus.ob_we         = ob_we_q;
  assign bus.ib_re         = ib_re;
  assign bus.mem_cmd_en    = cmd_en;
  assign bus.mem_cmd_instr = cmd_instr;
  assign bus.mem_cmd_addr  = addr_q;
  assign bus.mem_cmd_bl    = CMD_BL_W'(BURST_LEN - 1);
  assign bus.mem_wr_en     = wr_push;
  assign bus.mem_wr_data   = (state == WR_DRAIN) ? wbuf_rdata : '0;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_dma_port.sv
// Randomised bench for dma_port: a transaction-level memory/engine model
// predicts the command, read-word and write-word streams of every burst.
module tb_dma_port;
  import dma_port_pkg::*;

  localparam int BL = 16;
  localparam int AW = 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_port_if #(.ADDR_W(AW)) bus();

  dma_port #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int rd_pending, eng_pending, cmd_full_hold;
  bit stress, bp_mode, seq_mode, inject_rd, inject_ib;
  logic [15:0] rd_seq, wr_seq;
  logic [15:0] exp_ob[$];
  logic [15:0] exp_wr[$];

  int cmd_count, ob_cnt, wr_cnt, done_cnt, viol, cmd_cyc, done_cyc, wr_at_cmd;
  bit busy_seen, done_with_last, cmd_instr_q;
  logic [AW-1:0] cmd_addr_q;
  logic [5:0] cmd_bl_q;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of environment: memory returns owed read words, engine answers
  // outstanding ib_re requests, then the cycle's outputs are recorded.
  task automatic applyStimulus();
    logic [15:0] w;
    @(negedge clk);
    cyc++;
    if (cmd_full_hold > 0) begin
      bus.mem_cmd_full = 1'b1;
      cmd_full_hold--;
    end else begin
      bus.mem_cmd_full = stress ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    bus.mem_wr_full = bp_mode ? ~bus.mem_wr_full : (stress ? ($urandom_range(0, 2) == 0) : 1'b0);
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 16'($urandom);
    if (inject_rd) begin
      bus.mem_rd_valid = 1'b1;
    end else if (rd_pending > 0 && (!stress || $urandom_range(0, 1) == 0)) begin
      w = seq_mode ? rd_seq : 16'($urandom);
      rd_seq++;
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = w;
      exp_ob.push_back(w);
      rd_pending--;
    end
    bus.ib_valid = 1'b0;
    bus.ib_data  = 16'($urandom);
    if (inject_ib) begin
      bus.ib_valid = 1'b1;
    end else if (eng_pending > 0 && (!stress || $urandom_range(0, 1) == 0)) begin
      w = seq_mode ? wr_seq : 16'($urandom);
      wr_seq++;
      bus.ib_valid = 1'b1;
      bus.ib_data  = w;
      exp_wr.push_back(w);
      eng_pending--;
    end
    #1;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.mem_cmd_en) begin
      if (bus.mem_cmd_full) viol++;
      cmd_count++;
      cmd_instr_q = bus.mem_cmd_instr;
      cmd_addr_q  = bus.mem_cmd_addr;
      cmd_bl_q    = bus.mem_cmd_bl;
      cmd_cyc     = cyc;
      wr_at_cmd   = wr_cnt;
      if (bus.mem_cmd_instr) rd_pending += BL;
    end
    if (bus.mem_wr_en) begin
      if (bus.mem_wr_full) viol++;
      wr_cnt++;
      if (exp_wr.size() == 0) viol++;
      else checkOutput("mem_wr_data", bus.mem_wr_data, exp_wr.pop_front());
      if (bp_mode && wr_cnt == BL) cmd_full_hold = 5;
    end
    if (bus.ob_we) begin
      ob_cnt++;
      if (exp_ob.size() == 0) viol++;
      else checkOutput("ob_data", bus.ob_data, exp_ob.pop_front());
    end
    if (bus.ib_re) eng_pending++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      done_with_last = bus.ob_we && (ob_cnt == BL);
    end
  endtask

  task automatic clear_burst();
    cmd_count = 0; ob_cnt = 0; wr_cnt = 0; done_cnt = 0; viol = 0;
    cmd_cyc = -1; done_cyc = -1; wr_at_cmd = -1;
    busy_seen = 1'b0; done_with_last = 1'b0;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !busy_seen; i++) applyStimulus();
    checkOutput("busy_start", busy_seen, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500 && done_cnt == 0; i++) applyStimulus();
  endtask

  task automatic check_burst(input bit is_read, input logic [AW-1:0] a);
    checkOutput("cmd_count", cmd_count, 1);
    checkOutput("cmd_instr", cmd_instr_q, is_read);
    checkOutput("cmd_addr", cmd_addr_q, a);
    checkOutput("cmd_bl", cmd_bl_q, BL - 1);
    checkOutput("done_count", done_cnt, 1);
    checkOutput("protocol", viol, 0);
    if (is_read) begin
      checkOutput("ob_we_count", ob_cnt, BL);
      checkOutput("done_with_last", done_with_last, 1);
      checkOutput("rd_leftover", exp_ob.size(), 0);
      checkOutput("rd_wr_count", wr_cnt, 0);
    end else begin
      checkOutput("wr_count", wr_cnt, BL);
      checkOutput("wr_before_cmd", wr_at_cmd, BL);
      checkOutput("done_after_cmd", done_cyc - cmd_cyc, 1);
      checkOutput("wr_leftover", exp_wr.size(), 0);
      checkOutput("wr_ob_count", ob_cnt, 0);
    end
    checkOutput("err_clean", bus.err, 0);
  endtask

  task automatic run_burst(input bit is_read, input bit both, input logic [AW-1:0] a, input int hold);
    clear_burst();
    bus.addr = a;
    bus.reads_en  = is_read || both;
    bus.writes_en = !is_read || both;
    wait_busy();
    bus.addr = AW'($urandom);
    repeat (hold) applyStimulus();
    bus.reads_en  = 1'b0;
    bus.writes_en = 1'b0;
    wait_done();
    check_burst(is_read || both, a);
  endtask

  task automatic check_quiet(input string ph);
    checkOutput({ph, "_busy"}, bus.busy, 0);
    checkOutput({ph, "_done"}, bus.done, 0);
    checkOutput({ph, "_err"}, bus.err, 0);
    checkOutput({ph, "_ob_we"}, bus.ob_we, 0);
    checkOutput({ph, "_ob_data"}, bus.ob_data, 0);
    checkOutput({ph, "_ib_re"}, bus.ib_re, 0);
    checkOutput({ph, "_cmd_en"}, bus.mem_cmd_en, 0);
    checkOutput({ph, "_cmd_addr"}, bus.mem_cmd_addr, 0);
    checkOutput({ph, "_wr_en"}, bus.mem_wr_en, 0);
    checkOutput({ph, "_wr_data"}, bus.mem_wr_data, 0);
    checkOutput({ph, "_cmd_bl"}, bus.mem_cmd_bl, BL - 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ob.delete(); exp_wr.delete();
    rd_pending = 0; eng_pending = 0; cmd_full_hold = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.reads_en = 1'b0; bus.writes_en = 1'b0; bus.addr = '0;
    bus.ib_data = '0; bus.ib_valid = 1'b0; bus.mem_cmd_full = 1'b0;
    bus.mem_rd_data = '0; bus.mem_rd_valid = 1'b0; bus.mem_wr_full = 1'b0;
    stress = 0; bp_mode = 0; seq_mode = 0; inject_rd = 0; inject_ib = 0;
    rd_pending = 0; eng_pending = 0; cmd_full_hold = 0;
    clear_burst();
    repeat (3) @(negedge clk);
    #1;
    check_quiet("init");
    rst = 1'b0;

    seq_mode = 1; rd_seq = 16'hA000;
    run_burst(1'b1, 1'b0, AW'(32'h100), 0);
    wr_seq = 16'hB000;
    run_burst(1'b0, 1'b0, AW'(32'h200), 0);
    seq_mode = 0;

    bp_mode = 1; cmd_full_hold = 6;
    run_burst(1'b1, 1'b0, AW'(32'h120), 0);
    run_burst(1'b0, 1'b0, AW'(32'h220), 0);
    bp_mode = 0;

    // Both requests: read first; writes_en stays up so the write follows
    // after exactly one IDLE cycle
    clear_burst();
    bus.addr = AW'(32'h300); bus.reads_en = 1'b1; bus.writes_en = 1'b1;
    wait_busy();
    bus.reads_en = 1'b0; bus.addr = AW'(32'h340);
    wait_done();
    check_burst(1'b1, AW'(32'h300));
    checkOutput("idle_at_done", bus.busy, 0);
    clear_burst();
    applyStimulus();
    checkOutput("b2b_one_idle", busy_seen, 1);
    bus.writes_en = 1'b0;
    wait_done();
    check_burst(1'b0, AW'(32'h340));

    stress = 1;
    for (int n = 0; n < 20; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_burst(kind == 0, kind == 2, AW'($urandom), $urandom_range(0, 4));
    end
    stress = 0;

    clear_burst();
    applyStimulus();
    inject_rd = 1;
    applyStimulus();
    inject_rd = 0;
    repeat (2) applyStimulus();
    checkOutput("stray_rd_err", bus.err, 1);
    checkOutput("stray_rd_ob_we", ob_cnt, 0);

    // Reset in the middle of draining: nothing may reach memory afterwards
    clear_burst();
    bus.writes_en = 1'b1; bus.addr = AW'(32'h3F0);
    wait_busy();
    bus.writes_en = 1'b0;
    for (int i = 0; i < 200 && wr_cnt < 3; i++) applyStimulus();
    checkOutput("drain_started", wr_cnt >= 3, 1);
    pulse_reset();
    clear_burst();
    repeat (40) applyStimulus();
    checkOutput("post_rst_cmd", cmd_count, 0);
    checkOutput("post_rst_wr", wr_cnt, 0);
    checkOutput("post_rst_busy", busy_seen, 0);

    inject_ib = 1;
    applyStimulus();
    inject_ib = 0;
    repeat (2) applyStimulus();
    checkOutput("stray_ib_err", bus.err, 1);
    pulse_reset();

    run_burst(1'b0, 1'b0, AW'(32'h1234), 2);
    run_burst(1'b1, 1'b0, AW'(32'h5678), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dma_port.md
DMA_PORT -- requirements
Module: dma_port

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16: 16-bit words per burst, range 2..64.
REQ-002 SHALL have parameter ADDR_W, default 30: word address width.
REQ-003 clk  in  1  clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 reads_en  in  1  engine read-burst request, level.
REQ-006 writes_en  in  1  engine write-burst request, level.
REQ-007 addr  in  ADDR_W  burst start address from engine.
REQ-008 ob_data  out  16  read word to engine.
REQ-009 ob_we  out  1  one-cycle strobe, ob_data valid.
REQ-010 ib_re  out  1  request for one write word from engine.
REQ-011 ib_data  in  16  write word from engine.
REQ-012 ib_valid  in  1  ib_data valid.
REQ-013 mem_cmd_en  out  1  memory command strobe.
REQ-014 mem_cmd_instr  out  1  1 = read, 0 = write.
REQ-015 mem_cmd_addr  out  ADDR_W  latched burst address.
REQ-016 mem_cmd_bl  out  6  constant BURST_LEN-1.
REQ-017 mem_cmd_full  in  1  memory command queue full.
REQ-018 mem_rd_data / mem_rd_valid  in  16 / 1  memory read return; cannot be back-pressured.
REQ-019 mem_wr_data / mem_wr_en  out  16 / 1  memory write data push.
REQ-020 mem_wr_full  in  1  memory write FIFO full.
REQ-021 busy / done / err  out  1 each  not IDLE; one-cycle end-of-burst pulse; sticky protocol error.

Function
REQ-022 FSM states SHALL be IDLE, RD_CMD, RD_DATA, WR_FILL, WR_DRAIN, WR_CMD.
REQ-023 IDLE: reads_en -> RD_CMD; else writes_en -> WR_FILL; both high -> read wins. addr SHALL be latched on the IDLE exit edge.
REQ-024 RD_CMD: mem_cmd_en=1, instr=1 for exactly one cycle when mem_cmd_full=0, then RD_DATA. Hold RD_CMD while full.
REQ-025 RD_DATA: each mem_rd_valid SHALL register mem_rd_data into ob_data and pulse ob_we on the next cycle (latency 1). The BURST_LEN-th word SHALL return the block to IDLE with done=1 in the same cycle as that ob_we.
REQ-026 WR_FILL: ib_re=1 while req_cnt<BURST_LEN. req_cnt increments each ib_re cycle. Each ib_valid word SHALL be stored at wbuf[rx_cnt], rx_cnt++. rx_cnt==BURST_LEN -> WR_DRAIN. ib_valid with rx_cnt==BURST_LEN is dropped.
REQ-027 WR_DRAIN: mem_wr_en=1, mem_wr_data=wbuf[tx_cnt] in each cycle mem_wr_full=0, tx_cnt++. After BURST_LEN pushes -> WR_CMD.
REQ-028 WR_CMD: mem_cmd_en=1, instr=0 for one cycle when mem_cmd_full=0, then IDLE with done=1.
REQ-029 Re-sampling: reads_en/writes_en held high SHALL start the next burst from IDLE, which enforces a minimum of one IDLE cycle between bursts.
REQ-030 Request drops: deasserting reads_en/writes_en mid-burst SHALL NOT abort the burst.
REQ-031 err SHALL set on mem_rd_valid outside RD_DATA (word discarded, no ob_we) and on ib_valid outside WR_FILL. err clears only on rst.
REQ-032 Counters SHALL be clog2(BURST_LEN)+1 bits and never wrap within a burst.

Reset
REQ-033 rst SHALL force IDLE immediately and clear all outputs to 0, including ob_data, mem_cmd_addr, mem_wr_data and err; mem_cmd_bl remains BURST_LEN-1.
REQ-034 rst mid-burst SHALL discard buffered words, with no memory command issued afterwards.

Structure
REQ-035 State encodings and the default BURST_LEN SHALL live in the shared accelerator package, alongside the engine op-type constants.
REQ-036 wbuf SHALL be a sub-module dma_wbuf: BURST_LEN x 16 register file, 1 write port, 1 read port.

Verification
REQ-037 Read burst: reads_en=1, addr=0x100; memory returns 16 words 0xA000..0xA00F -> one mem_cmd_en (instr=1, addr=0x100, bl=15), 16 ob_we in order, done with the 16th.
REQ-038 Write burst: writes_en=1, addr=0x200; engine answers ib_re one cycle later with 0xB000..0xB00F -> 16 mem_wr_en in order, then mem_cmd_en (instr=0, addr=0x200), done.
REQ-039 Backpressure: mem_cmd_full=1 for 5 cycles, mem_wr_full toggling -> no data lost or duplicated, single command per burst.
REQ-040 Priority/back-to-back: reads_en and writes_en both high -> read burst, one IDLE cycle, then write burst.
REQ-041 Errors: mem_rd_valid pulse in IDLE -> err=1, no ob_we. rst mid-WR_DRAIN -> outputs 0, no mem_cmd_en afterwards.
